// File: rtl/mem_pkg.sv
// Shared defaults and control-state encoding for the mem_responder block.
package mem_pkg;

    localparam int          ADDR_W_DEF    = 2;
    localparam int          DATA_W_DEF    = 8;
    localparam logic [7:0]  RESET_VAL_DEF = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        ERR  = 2'b10
    } state_e;

endpackage : mem_pkg

// File: rtl/mem_regfile.sv
// Word storage: one write port, one registered read port, every word
// returns to RESET_VAL asynchronously on reset.
module mem_regfile
    import mem_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(RESET_VAL_DEF)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Storage array: the full address space is populated, so no range check.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VAL;
            end
        end else if (wr_en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read data holds its last value whenever no read is accepted.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en_i) begin
            rdata_d = mem_q[addr_i];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read data register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= {DATA_W{1'b0}};
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule : mem_regfile

// File: rtl/mem_responder.sv
// Single-port memory responder: accepts reads or writes each cycle, rejects
// simultaneous read+write with a one-cycle err pulse, counts accepted accesses.
module mem_responder
    import mem_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(RESET_VAL_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_valid,
    output logic              err,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       rd_cnt
);

    state_e      state_q;
    state_e      state_d;
    logic        wr_accept_s;
    logic        rd_accept_s;
    logic [15:0] wr_cnt_q;
    logic [15:0] wr_cnt_d;
    logic [15:0] rd_cnt_q;
    logic [15:0] rd_cnt_d;

    // Access decode: a collision suppresses both the read and the write.
    always_comb begin
        wr_accept_s = 1'b0;
        rd_accept_s = 1'b0;
        state_d     = IDLE;
        case ({wr_en, rd_en})
            2'b10: begin
                wr_accept_s = 1'b1;
                state_d     = IDLE;
            end
            2'b01: begin
                rd_accept_s = 1'b1;
                state_d     = RD;
            end
            2'b11: begin
                state_d     = ERR;
            end
            2'b00: begin
                state_d     = IDLE;
            end
            default: begin
                state_d     = IDLE;
            end
        endcase
    end

    // Access counters wrap silently through 16'hFFFF.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (wr_accept_s) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end else begin
            wr_cnt_d = wr_cnt_q;
        end
        if (rd_accept_s) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end else begin
            rd_cnt_d = rd_cnt_q;
        end
    end

    // Control state and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_cnt_q <= 16'd0;
            rd_cnt_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    mem_regfile #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VAL)
    ) u_regfile (
        .clk_i   (clk),
        .rst_i   (reset),
        .addr_i  (addr),
        .wr_en_i (wr_accept_s),
        .wdata_i (wdata),
        .rd_en_i (rd_accept_s),
        .rdata_o (rdata)
    );

    // Status flags come straight from the state register, so a reset clears them at once.
    assign rd_valid = (state_q == RD);
    assign err      = (state_q == ERR);
    assign wr_cnt   = wr_cnt_q;
    assign rd_cnt   = rd_cnt_q;

endmodule : mem_responder

// File: tb/tb_mem_responder.sv
// Directed plus randomized bench for mem_responder, checked against an
// array-based reference model of the memory and its access counters.
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        rd_valid;
    logic        err;
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]  mem_m [4];
    logic [7:0]  exp_rdata;
    logic        exp_valid;
    logic        exp_err;
    logic [15:0] exp_wcnt;
    logic [15:0] exp_rcnt;

    mem_responder dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .wdata    (wdata),
        .rdata    (rdata),
        .rd_valid (rd_valid),
        .err      (err),
        .wr_cnt   (wr_cnt),
        .rd_cnt   (rd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rdata"},    {8'h00, rdata},    {8'h00, exp_rdata});
        check({tag, ".rd_valid"}, {15'd0, rd_valid}, {15'd0, exp_valid});
        check({tag, ".err"},      {15'd0, err},      {15'd0, exp_err});
        check({tag, ".wr_cnt"},   wr_cnt,            exp_wcnt);
        check({tag, ".rd_cnt"},   rd_cnt,            exp_rcnt);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mem_m[i] = 8'h00;
        exp_rdata = 8'h00;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_wcnt  = 16'd0;
        exp_rcnt  = 16'd0;
    endtask

    // One clock of stimulus; model advances at the edge, outputs checked 1 unit later.
    task automatic cycle(input string tag, input logic w, input logic r,
                         input logic [1:0] a, input logic [7:0] d);
        wr_en = w;
        rd_en = r;
        addr  = a;
        wdata = d;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            exp_err   = w & r;
            exp_valid = r & ~w;
            if (exp_valid) begin
                exp_rdata = mem_m[a];
                exp_rcnt  = exp_rcnt + 16'd1;
            end
            if (w & ~r) begin
                mem_m[a] = d;
                exp_wcnt = exp_wcnt + 16'd1;
            end
        end
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_all(tag);
    endtask

    initial begin
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        addr  = 2'd0;
        wdata = 8'h00;
        model_reset();
        #1;
        check_all("reset_state");

        // Accesses while reset is held are discarded
        cycle("reset_wr", 1'b1, 1'b0, 2'd1, 8'hEE);
        cycle("reset_rd", 1'b0, 1'b1, 2'd1, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // Reset contents of every word
        for (int a = 0; a < 4; a++) cycle("rd_reset_val", 1'b0, 1'b1, 2'(a), 8'h00);
        check("rd_cnt_after_4", rd_cnt, 16'd4);

        // Write then immediate read of the same word
        cycle("wr_a5", 1'b1, 1'b0, 2'd2, 8'hA5);
        cycle("rd_a5", 1'b0, 1'b1, 2'd2, 8'h00);
        check("rdata_a5", {8'h00, rdata}, 16'h00A5);

        // Collision leaves memory and counters untouched
        cycle("collide", 1'b1, 1'b1, 2'd1, 8'h3C);
        cycle("rd_after_coll", 1'b0, 1'b1, 2'd1, 8'h00);
        check("rdata_after_coll", {8'h00, rdata}, 16'h0000);
        cycle("idle_after_coll", 1'b0, 1'b0, 2'd0, 8'h00);

        // Fill then back-to-back reads, then an idle cycle holding rdata
        for (int a = 0; a < 4; a++) cycle("fill", 1'b1, 1'b0, 2'(a), vals[a]);
        for (int a = 0; a < 4; a++) cycle("burst_rd", 1'b0, 1'b1, 2'(a), 8'h00);
        cycle("hold", 1'b0, 1'b0, 2'd0, 8'h00);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 8'($urandom));
        end

        // Reset asserted between edges in the middle of a read burst
        cycle("pre_rst_rd0", 1'b0, 1'b1, 2'd0, 8'h00);
        cycle("pre_rst_rd1", 1'b0, 1'b1, 2'd1, 8'h00);
        #2;
        rd_en = 1'b1;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        cycle("in_reset_wr", 1'b1, 1'b0, 2'd3, 8'hFF);
        @(negedge clk);
        reset = 1'b0;
        cycle("post_rst_idle", 1'b0, 1'b0, 2'd0, 8'h00);
        cycle("post_rst_rd", 1'b0, 1'b1, 2'd3, 8'h00);
        check("post_rst_rdata", {8'h00, rdata}, 16'h0000);

        // Write counter wrap
        for (int i = 0; i < 65535; i++) begin
            wr_en = 1'b1;
            rd_en = 1'b0;
            addr  = 2'(i);
            wdata = 8'(i);
            @(posedge clk);
            mem_m[2'(i)] = 8'(i);
            exp_wcnt = exp_wcnt + 16'd1;
        end
        exp_valid = 1'b0;
        #1;
        wr_en = 1'b0;
        check("wr_cnt_ffff", wr_cnt, 16'hFFFF);
        cycle("wrap_0", 1'b1, 1'b0, 2'd0, 8'h5A);
        cycle("wrap_1", 1'b1, 1'b0, 2'd1, 8'h6B);
        check("wr_cnt_65537", wr_cnt, 16'h0001);
        cycle("wrap_rd", 1'b0, 1'b1, 2'd1, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mem_responder

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 2, address width; depth is 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 8, word width.
REQ-003 Parameter RESET_VAL, default 8'h00, value loaded into every word at reset.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 addr  input  ADDR_W  word address for the current access.
REQ-007 wr_en  input  1  write request, sampled at posedge clk.
REQ-008 rd_en  input  1  read request, sampled at posedge clk.
REQ-009 wdata  input  DATA_W  write data, valid with wr_en.
REQ-010 rdata  output  DATA_W  registered read data.
REQ-011 rd_valid  output  1  rdata carries data for a read accepted on the previous edge.
REQ-012 err  output  1  one-cycle pulse flagging a rejected access.
REQ-013 wr_cnt  output  16  count of accepted writes, wraps at 16'hFFFF->0.
REQ-014 rd_cnt  output  16  count of accepted reads, wraps at 16'hFFFF->0.

Function
REQ-015 Write: wr_en=1, rd_en=0 at an edge -> mem[addr] <= wdata at that edge; wr_cnt increments.
REQ-016 Read: rd_en=1, wr_en=0 at edge N -> rdata = mem[addr] and rd_valid=1 after edge N; latency exactly 1 cycle; rd_cnt increments.
REQ-017 Back-to-back reads every cycle are accepted; rd_valid stays high continuously.
REQ-018 No read at an edge -> rd_valid=0 after that edge; rdata holds its last value.
REQ-019 Read after write: write to A at edge N, read of A at edge N+1 -> returns the new data; no stale-data hazard.
REQ-020 Collision: wr_en=1 and rd_en=1 at the same edge -> neither access performed, memory unchanged, counters unchanged, rd_valid=0, err=1 for exactly one cycle.
REQ-021 err is 0 in every cycle that does not follow a collision edge.
REQ-022 Each addr value in 0..2**ADDR_W-1 maps to a distinct word; no out-of-range case exists.
REQ-023 Counters wrap silently; no saturation and no flag on wrap.
REQ-024 Control FSM states: IDLE (no access), RD (read accepted on last edge), ERR (collision on last edge); next state decoded solely from wr_en/rd_en each edge; WRITE needs no state because it completes at its edge.
REQ-025 rd_valid = (state==RD); err = (state==ERR); both outputs are registered.

Reset
REQ-026 reset=1 immediately, without waiting for a clock edge, forces: all words = RESET_VAL, rdata=0, rd_valid=0, err=0, wr_cnt=0, rd_cnt=0, FSM=IDLE.
REQ-027 A read or write coincident with an edge while reset=1 is discarded.
REQ-028 Reset asserted mid-stream: rd_valid falls in the same cycle, with no trailing valid after release.
REQ-029 First access is accepted at the first posedge after reset deasserts.

Structure
REQ-030 Shared package mem_pkg holds ADDR_W, DATA_W and RESET_VAL defaults, plus the FSM state enum (IDLE, RD, ERR).
REQ-031 Storage is the sub-module mem_regfile: one write port, one registered read port, and async reset of all words; mem_responder holds the FSM, counters and collision logic.

Verification
REQ-032 Reset, then read addr 0..3 -> rdata=8'h00 with rd_valid=1 one cycle after each rd_en; rd_cnt=4.
REQ-033 Write 8'hA5 to addr 2, read addr 2 on the next cycle -> rdata=8'hA5 one cycle later; wr_cnt=1, rd_cnt=1.
REQ-034 wr_en=rd_en=1 at addr 1 with wdata=8'h3C, then read addr 1 -> err=1 for one cycle, read returns 8'h00, and both counters are unchanged by the collision.
REQ-035 Write 11,22,33,44 to addr 0..3, then four back-to-back reads -> rdata 11,22,33,44 on consecutive cycles, with rd_valid high for 4 cycles.
REQ-036 Assert reset between clock edges during a read burst -> rd_valid, rdata and counters go to 0 immediately, and a read after release returns RESET_VAL.
REQ-037 Issue 65537 writes -> wr_cnt=16'h0001.
